m6809_uart_tx: RTL
==================

Name: m6809_uart_tx

Overview:
- Memory-mapped serial transmit peripheral on the 6809 core bus, alongside the RAM and boot ROM in the integration layer.
- Consumes CPU writes (address, core data out, data_rw_n) and buffers bytes in a small FIFO.
- Serialises bytes as 8N1 frames on txd; provides status/baud registers for CPU reads through the integration data mux.

Parameters:
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, 2..64.
- BAUD_DIV_RESET, 16'd434, reset value of the baud divisor (clocks per bit).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sel  input  1  chip select from the integration address decode.
- a  input  2  register address (core address[1:0]).
- din  input  8  write data (core data_out).
- data_rw_n  input  1  1 = read, 0 = write.
- dout  output  8  read data to the core data-in mux; combinational from a and registers.
- txd  output  1  serial output, idle high, registered.
- busy  output  1  high when a frame is in progress or the FIFO is non-empty.

Behaviour:
- Write strobe: sel & ~data_rw_n at a clk edge. No read side effects.
- Register map:
  - 0 DATA: write pushes din into the FIFO; read returns 0x00.
  - 1 STATUS: bit0 tx_active, bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bits7:4 read 0. Writing bit3 = 1 clears overflow.
  - 2 BAUD_LO, 3 BAUD_HI: 16-bit divisor, read/write.
- Reset values: txd = 1, busy = 0, FIFO empty, overflow = 0, divisor = BAUD_DIV_RESET, FSM = IDLE, dout per STATUS = 0x04.
- Divisor 0 is treated as 1. A new divisor takes effect at the next bit-counter reload, never mid-bit.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE, FIFO non-empty: pop head into the shift register, load the bit counter, go to START, drive txd = 0.
  - START: txd = 0 for divisor clocks, then DATA.
  - DATA: 8 bits LSB first, divisor clocks each, tracked by a 3-bit index; after bit 7, go to STOP.
  - STOP: txd = 1 for divisor clocks. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: write at edge E0; FIFO non-empty after E0; txd falls after E1. One frame = 10 × divisor clocks.
- FIFO is full when it holds FIFO_DEPTH entries.
  - Write when full with no pop that cycle: data dropped, overflow set.
  - Write when full with a pop the same cycle: accepted; count unchanged.
  - Push and pop the same cycle when not full: both happen.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- busy = (state != IDLE) | ~fifo_empty.
- Reset mid-frame: the frame is aborted, txd returns high after the reset edge, and FIFO contents are discarded.
- Writes to a = 1 only affect bit3; other bits are read-only.

Optional Feature:
- Macro: M6809_UART_TX_IRQ_EN.
- Defined:
  - Adds output port irq_b (1 bit, active low, registered, reset value 1).
  - STATUS bit7 becomes a read/write irq enable, reset 0.
  - irq_b = 0 when the enable is 1, the FIFO is empty and the state is IDLE.
  - The condition is level-based; irq_b clears the cycle after a DATA write or after the enable is cleared.
- Undefined: no irq_b port; STATUS bit7 reads 0 and ignores writes.

Test Plan:
- Reset then read STATUS -> 0x04; BAUD_LO/HI read 0xB2/0x01; txd = 1, busy = 0.
- Set divisor 4, write DATA 0xA5 -> txd low 1 clock after the write for 4 clocks. Data bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop high for 4 clocks, frame = 40 clocks. busy low after the stop bit ends.
- Divisor 2: write 9 bytes 0x00..0x08 back-to-back within 9 cycles -> first byte popped, FIFO holds 8, nothing lost, overflow = 0. A 10th write before any further pop sets STATUS bit3 and is dropped. Output shows frames 0x00..0x08 with no idle gap between stop and start.
- Write STATUS 0x08 -> overflow clears; STATUS bit1/bit2 track count exactly at 7/8 entries and at 0.
- Divisor 0 -> behaves as divisor 1 (10-clock frame). Change divisor 2→6 during DATA bit 3: current bit completes at 2 clocks, bit 4 onward at 6.
- Assert reset during DATA bit 5 with 3 bytes queued -> after reset txd = 1, STATUS = 0x04, no further start bits. With M6809_UART_TX_IRQ_EN and enable set, irq_b = 0 once idle and empty, and returns to 1 one cycle after a DATA write.

Source files
------------

// File: rtl/m6809_uart_tx_if.sv
// rtl/m6809_uart_tx_if.sv - CPU register bus between the 6809 core decode and the UART transmitter
interface m6809_uart_tx_if;
    logic       sel;
    logic [1:0] a;
    logic [7:0] din;
    logic       data_rw_n;
    logic [7:0] dout;

    modport master (output sel, output a, output din, output data_rw_n, input dout);
    modport slave  (input sel, input a, input din, input data_rw_n, output dout);
endinterface

// File: rtl/m6809_uart_tx.sv
// rtl/m6809_uart_tx.sv - 8N1 UART transmitter with FIFO and register map; optional irq_b via M6809_UART_TX_IRQ_EN
module m6809_uart_tx #(
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd434
) (
    input  logic              clk,
    input  logic              reset,
    m6809_uart_tx_if.slave    bus,
    output logic              txd,
`ifdef M6809_UART_TX_IRQ_EN
    output logic              irq_b,
`endif
    output logic              busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   div, div_eff, reload, cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          txd_n, pop, push, push_req, wr, fifo_empty, fifo_full;
    logic          overflow, irq_en;

    assign wr         = bus.sel & ~bus.data_rw_n;
    assign push_req   = wr & (bus.a == 2'd0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    // A full FIFO still accepts a write when the head is leaving on the same edge.
    assign push       = push_req & (~fifo_full | pop);
    // Divisor is sampled only at counter reloads so a bit never changes length mid-way.
    assign div_eff    = (div == 16'd0) ? 16'd1 : div;
    assign reload     = div_eff - 16'd1;
    assign busy       = (state != IDLE) | ~fifo_empty;

    // Frame sequencing: next state, bit timing, shift register and next txd level.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        txd_n   = txd;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_n    = mem[rd_ptr];
                    cnt_n   = reload;
                    state_n = START;
                    txd_n   = 1'b0;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    state_n = DATA;
                    txd_n   = sh[0];
                    sh_n    = {1'b0, sh[7:1]};
                    idx_n   = 3'd0;
                    cnt_n   = reload;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_n = reload;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        idx_n = idx + 3'd1;
                        txd_n = sh[0];
                        sh_n  = {1'b0, sh[7:1]};
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        sh_n    = mem[rd_ptr];
                        cnt_n   = reload;
                        state_n = START;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame state registers; reset aborts any frame and forces the line idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 16'd0;
            idx   <= 3'd0;
            sh    <= 8'd0;
            txd   <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            txd   <= txd_n;
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Writable registers: divisor, sticky overflow, irq enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= BAUD_DIV_RESET;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (wr && bus.a == 2'd1 && bus.din[3]) begin
                overflow <= 1'b0;
            end
            if (wr && bus.a == 2'd2) div[7:0]  <= bus.din;
            if (wr && bus.a == 2'd3) div[15:8] <= bus.din;
`ifdef M6809_UART_TX_IRQ_EN
            if (wr && bus.a == 2'd1) irq_en <= bus.din[7];
`endif
        end
    end

`ifdef M6809_UART_TX_IRQ_EN
    // Level interrupt: asserted while enabled and the transmitter has fully drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_b <= 1'b1;
        end else begin
            irq_b <= ~(irq_en & fifo_empty & (state == IDLE));
        end
    end
`endif

    // Read mux; reads have no side effects.
    always_comb begin
        bus.dout = 8'h00;
        case (bus.a)
            2'd1:    bus.dout = {irq_en, 3'b000, overflow, fifo_empty, fifo_full, state != IDLE};
            2'd2:    bus.dout = div[7:0];
            2'd3:    bus.dout = div[15:8];
            default: bus.dout = 8'h00;
        endcase
    end
endmodule
